// File: rtl/store_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_fifo
// Brief    : In-order store buffer with youngest-entry coalescing, oldest-first
//            drain and youngest-match load forwarding.
// Revision : 1.0
// ============================================================================
module store_buffer_fifo #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 28,
    parameter int DATA_W   = 32,
    parameter int COALESCE = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [DATA_W-1:0]          push_data,
    input  logic [DATA_W/8-1:0]        push_be,
    output logic                       drain_valid,
    input  logic                       drain_ready,
    output logic [ADDR_W-1:0]          drain_addr,
    output logic [DATA_W-1:0]          drain_data,
    output logic [DATA_W/8-1:0]        drain_be,
    input  logic                       search_valid,
    input  logic [ADDR_W-1:0]          search_addr,
    output logic                       search_hit,
    output logic [DATA_W-1:0]          search_data,
    output logic [DATA_W/8-1:0]        search_be,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_BE_W  = DATA_W / 8;

    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [c_BE_W-1:0]  r_be   [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               w_empty;
    logic               w_full;
    logic [c_PTR_W-1:0] w_young;
    logic               w_drain_fire;
    logic               w_coalesce_hit;
    logic               w_push_fire;
    logic               w_push_new;
    logic [c_PTR_W-1:0] w_idx;
    logic               w_search_hit;
    logic [DATA_W-1:0]  w_search_data;
    logic [c_BE_W-1:0]  w_search_be;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == c_CNT_W'(DEPTH));
    assign w_young      = r_tail - c_PTR_W'(1);
    assign w_drain_fire = !w_empty && drain_ready;

    // Merging is barred when the only entry is leaving this very cycle.
    generate
        if (COALESCE != 0) begin : g_coalesce
            assign w_coalesce_hit = !w_empty
                                 && (push_addr == r_addr[w_young])
                                 && !((r_count == c_CNT_W'(1)) && w_drain_fire);
        end else begin : g_no_coalesce
            assign w_coalesce_hit = 1'b0;
        end
    endgenerate

    assign push_ready  = !flush && (!w_full || w_coalesce_hit);
    assign w_push_fire = push_valid && push_ready;
    assign w_push_new  = w_push_fire && !w_coalesce_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_drain_fire) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            if (w_push_new) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            r_count <= r_count + {{(c_CNT_W-1){1'b0}}, w_push_new}
                               - {{(c_CNT_W-1){1'b0}}, w_drain_fire};
        end
    end

    // Payload storage carries no reset; validity is defined by head/count.
    always_ff @(posedge clock) begin
        if (w_push_fire) begin
            if (w_coalesce_hit) begin
                for (int b = 0; b < c_BE_W; b++) begin
                    if (push_be[b]) begin
                        r_data[w_young][b*8 +: 8] <= push_data[b*8 +: 8];
                    end
                end
                r_be[w_young] <= r_be[w_young] | push_be;
            end else begin
                r_addr[r_tail] <= push_addr;
                r_data[r_tail] <= push_data;
                r_be[r_tail]   <= push_be;
            end
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        w_idx         = '0;
        w_search_hit  = 1'b0;
        w_search_data = '0;
        w_search_be   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + c_PTR_W'(i);
            if (search_valid && (c_CNT_W'(i) < r_count)
                && (r_addr[w_idx] == search_addr)) begin
                w_search_hit  = 1'b1;
                w_search_data = r_data[w_idx];
                w_search_be   = r_be[w_idx];
            end
        end
    end

    assign search_hit  = w_search_hit;
    assign search_data = w_search_data;
    assign search_be   = w_search_be;

    assign drain_valid = !w_empty;
    assign drain_addr  = r_addr[r_head];
    assign drain_data  = r_data[r_head];
    assign drain_be    = r_be[r_head];

    assign count = r_count;
    assign empty = w_empty;
    assign full  = w_full;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer_fifo
// Brief    : Directed plus randomized bench with a queue-based store buffer model.
// Revision : 1.0
// ============================================================================
module tb_store_buffer_fifo;

    localparam int DEPTH    = 4;
    localparam int COALESCE = 1;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        push_valid;
    logic        push_ready;
    logic [27:0] push_addr;
    logic [31:0] push_data;
    logic [3:0]  push_be;
    logic        drain_valid;
    logic        drain_ready;
    logic [27:0] drain_addr;
    logic [31:0] drain_data;
    logic [3:0]  drain_be;
    logic        search_valid;
    logic [27:0] search_addr;
    logic        search_hit;
    logic [31:0] search_data;
    logic [3:0]  search_be;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    store_buffer_fifo #(
        .DEPTH(DEPTH), .ADDR_W(28), .DATA_W(32), .COALESCE(COALESCE)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_addr(push_addr), .push_data(push_data), .push_be(push_be),
        .drain_valid(drain_valid), .drain_ready(drain_ready),
        .drain_addr(drain_addr), .drain_data(drain_data), .drain_be(drain_be),
        .search_valid(search_valid), .search_addr(search_addr),
        .search_hit(search_hit), .search_data(search_data), .search_be(search_be),
        .count(count), .empty(empty), .full(full)
    );

    typedef struct {
        logic [27:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } ent_t;

    ent_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   last_accepted;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, update the model, advance.
    task automatic cyc(input bit pv, input logic [27:0] pa, input logic [31:0] pd,
                       input logic [3:0] pbe, input bit dr, input bit sv,
                       input logic [27:0] sa, input bit fl);
        int   n;
        bit   e_full, e_dv, e_df, e_hit, e_pr, sh;
        logic [31:0] sd;
        logic [3:0]  sb;
        ent_t t;
        push_valid   = pv;
        push_addr    = pa;
        push_data    = pd;
        push_be      = pbe;
        drain_ready  = dr;
        search_valid = sv;
        search_addr  = sa;
        flush        = fl;
        #1;
        n      = q.size();
        e_full = (n == DEPTH);
        e_dv   = (n != 0);
        e_df   = e_dv && dr;
        e_hit  = (COALESCE != 0) && (n >= 1) && (q[n-1].a == pa) && !(n == 1 && e_df);
        e_pr   = !fl && (!e_full || e_hit);
        sh = 1'b0; sd = '0; sb = '0;
        if (sv) begin
            foreach (q[k]) begin
                if (q[k].a == sa) begin
                    sh = 1'b1; sd = q[k].d; sb = q[k].b;
                end
            end
        end
        chk("count", 64'(count), 64'(n));
        chk("empty", 64'(empty), 64'(n == 0));
        chk("full", 64'(full), 64'(e_full));
        chk("drain_valid", 64'(drain_valid), 64'(e_dv));
        chk("push_ready", 64'(push_ready), 64'(e_pr));
        chk("search_hit", 64'(search_hit), 64'(sh));
        chk("search_data", 64'(search_data), 64'(sd));
        chk("search_be", 64'(search_be), 64'(sb));
        if (e_dv) begin
            chk("drain_addr", 64'(drain_addr), 64'(q[0].a));
            chk("drain_data", 64'(drain_data), 64'(q[0].d));
            chk("drain_be", 64'(drain_be), 64'(q[0].b));
        end
        last_accepted = pv && e_pr;
        if (fl) begin
            q.delete();
        end else begin
            if (last_accepted && e_hit) begin
                t = q[n-1];
                for (int b = 0; b < 4; b++) begin
                    if (pbe[b]) t.d[b*8 +: 8] = pd[b*8 +: 8];
                end
                t.b = t.b | pbe;
                q[n-1] = t;
            end
            if (e_df) void'(q.pop_front());
            if (last_accepted && !e_hit) begin
                t.a = pa; t.d = pd; t.b = pbe;
                q.push_back(t);
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input bit dr, input bit sv, input logic [27:0] sa);
        cyc(1'b0, 28'h0, 32'h0, 4'h0, dr, sv, sa, 1'b0);
    endtask

    task automatic check_reset_values(input string phase);
        chk({phase, "_count"}, 64'(count), 64'd0);
        chk({phase, "_empty"}, 64'(empty), 64'd1);
        chk({phase, "_full"}, 64'(full), 64'd0);
        chk({phase, "_drain_valid"}, 64'(drain_valid), 64'd0);
        chk({phase, "_push_ready"}, 64'(push_ready), 64'd1);
        chk({phase, "_search_hit"}, 64'(search_hit), 64'd0);
    endtask

    initial begin
        int pushed;
        int guard;
        reset = 1'b1; flush = 1'b0; push_valid = 1'b0; push_addr = '0;
        push_data = '0; push_be = '0; drain_ready = 1'b0;
        search_valid = 1'b1; search_addr = 28'h10;
        #1;
        check_reset_values("por");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Basic push, one-cycle latency to drain, then drain to empty
        cyc(1'b1, 28'h10, 32'h11223344, 4'hF, 1'b0, 1'b1, 28'h10, 1'b0);
        idle(1'b1, 1'b1, 28'h10);
        idle(1'b0, 1'b0, 28'h0);

        // Fill with distinct addresses, stall on full with drain, wrap pointers
        pushed = 0;
        guard  = 0;
        while (pushed < 8 && guard < 40) begin
            cyc(1'b1, 28'h1 + 28'(pushed), 32'hA0 + 32'(pushed), 4'hF,
                pushed >= 4, 1'b1, 28'h3, 1'b0);
            if (last_accepted) pushed++;
            guard++;
        end
        chk("wrap_push_budget", 64'(pushed), 64'd8);
        for (int i = 0; i < 6; i++) idle(1'b1, 1'b1, 28'h7);

        // Coalesce into youngest, then blocked coalesce while sole entry drains
        cyc(1'b1, 28'h20, 32'h000000AA, 4'h1, 1'b0, 1'b0, 28'h0, 1'b0);
        cyc(1'b1, 28'h20, 32'hBB000000, 4'h8, 1'b0, 1'b1, 28'h20, 1'b0);
        idle(1'b0, 1'b1, 28'h20);
        cyc(1'b1, 28'h20, 32'hBB000000, 4'h8, 1'b1, 1'b1, 28'h20, 1'b0);
        idle(1'b1, 1'b1, 28'h20);
        idle(1'b0, 1'b0, 28'h0);

        // Youngest-match forwarding when the older copy is not the youngest entry
        cyc(1'b1, 28'h30, 32'h00001111, 4'h3, 1'b0, 1'b0, 28'h0, 1'b0);
        cyc(1'b1, 28'h40, 32'h44444444, 4'hF, 1'b0, 1'b0, 28'h0, 1'b0);
        cyc(1'b1, 28'h30, 32'h22220000, 4'hC, 1'b0, 1'b0, 28'h0, 1'b0);
        idle(1'b0, 1'b1, 28'h30);
        idle(1'b0, 1'b1, 28'h50);
        idle(1'b0, 1'b0, 28'h50);

        // Flush with three entries and a concurrent drain
        cyc(1'b1, 28'h60, 32'h66666666, 4'hF, 1'b1, 1'b1, 28'h40, 1'b1);
        idle(1'b0, 1'b1, 28'h30);

        // Asynchronous reset with two entries held
        cyc(1'b1, 28'h70, 32'h70707070, 4'hF, 1'b0, 1'b0, 28'h0, 1'b0);
        cyc(1'b1, 28'h71, 32'h71717171, 4'hF, 1'b0, 1'b0, 28'h0, 1'b0);
        push_valid = 1'b0; search_valid = 1'b1; search_addr = 28'h70; flush = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check_reset_values("async");
        q.delete();
        @(negedge clock);
        reset = 1'b0;
        cyc(1'b1, 28'h77, 32'h77777777, 4'h5, 1'b0, 1'b0, 28'h0, 1'b0);
        cyc(1'b1, 28'h78, 32'h78787878, 4'hF, 1'b1, 1'b1, 28'h77, 1'b0);
        idle(1'b1, 1'b0, 28'h0);
        idle(1'b0, 1'b0, 28'h0);

        // Randomized traffic over a small address pool to exercise merge/forward
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 3) != 0, 28'h100 + 28'($urandom % 4), $urandom,
                4'($urandom % 16), ($urandom % 2) == 1, ($urandom % 2) == 1,
                28'h100 + 28'($urandom % 5), ($urandom % 40) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_buffer_fifo.md
# store_buffer_fifo

Parametrised, in-order store buffer between the core's memory stage and the data cache. Retired stores are queued, with optional coalescing into the youngest entry, and drained oldest-first to the cache over a valid/ready handshake. Loads search the buffer every cycle and receive youngest-match forwarding data with byte enables. Successor to the fixed two-entry buffer: depth, address/data widths and coalescing are generalised, and age ordering is strictly FIFO.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2
- ADDR_W, 28: word-address width (byte offset stripped)
- DATA_W, 32: data width; multiple of 8
- COALESCE, 1: 1 enables merging a push into the youngest entry
- clock  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous discard of all entries
- push_valid  in  1  store offered
- push_ready  out  1  store can be accepted
- push_addr  in  ADDR_W  store word address
- push_data  in  DATA_W  store data
- push_be  in  DATA_W/8  byte enables
- drain_valid  out  1  head entry present
- drain_ready  in  1  cache accepts head
- drain_addr / drain_data / drain_be  out  ADDR_W / DATA_W / DATA_W/8  head entry contents
- search_valid  in  1  load lookup
- search_addr  in  ADDR_W  load word address
- search_hit  out  1  some valid entry matches
- search_data / search_be  out  DATA_W / DATA_W/8  youngest matching entry
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count==0
- full  out  1  count==DEPTH

## Operation
- State: circular array, head/tail pointers ($clog2(DEPTH) bits, wrap modulo DEPTH), count register. Entry payload is not reset.
- Push fire = push_valid & push_ready. Drain fire = drain_valid & drain_ready.
- Coalesce hit (COALESCE=1): count≥1, push_addr equals the youngest entry's address, and that entry is not being drained this cycle (count==1 with drain fire blocks coalescing). On a hit, bytes with push_be=1 overwrite the youngest entry, its be becomes be|push_be, and count is unchanged.
- Push without coalesce hit: write to tail, tail+1, count+1.
- push_ready = !flush & (!full | coalesce_hit). A full buffer does not accept a non-coalescing push even when a drain fires the same cycle.
- drain_valid = !empty. Drain fire advances head and decrements count. Outputs come from the head entry; their value is undefined when empty.
- Simultaneous non-coalescing push and drain: count is unchanged and both pointers advance.
- Search is combinational over the registered state. search_hit = search_valid & any valid entry address match. search_data/search_be come from the youngest match (closest to tail). A push in the same cycle is not visible to search. A search never removes an entry. When there is no hit, search_data and search_be are 0.
- flush: next cycle head=tail=0 and count=0. Flush takes priority over push and drain. Drain fire in the flush cycle is still reported to the cache, i.e. the head handshake completes, then all entries are discarded.

## Timing
- Reset (async assert): count=0, empty=1, full=0, drain_valid=0, push_ready=1 (when flush=0), search_hit=0, pointers=0.
- Push-to-drain latency: a store pushed in cycle N appears at drain_valid in N+1 when the buffer was empty.
- Push-to-search visibility: 1 cycle.
- count/empty/full are registered-derived and update the cycle after a fire.
- Reset asserted mid-operation discards all entries immediately. No drain handshake is generated for them.

## Test plan
- Reset, then push A=0x10 D=0x11223344 be=0xF; next cycle drain_valid=1, drain_addr=0x10, count=1; drain_ready=1 → empty=1.
- DEPTH=4, COALESCE=0: push 4 distinct addresses → full=1, push_ready=0. Push + drain in the same cycle → push stalls. Drain order is identical to push order across pointer wrap (8 pushes total).
- COALESCE=1: push 0x20 D=0x000000AA be=0x1, then 0x20 D=0xBB000000 be=0x8 → count=1, drain_data=0xBB0000AA, drain_be=0x9. Same second push while count==1 with drain fire → count=1 (new entry, no merge).
- Pushes 0x30 be=0x3 D=0x1111, then 0x40, then 0x30 be=0xC D=0x22220000 (non-youngest, so no coalesce) → search 0x30: hit=1, data=0x22220000, be=0xC. Search 0x50 → hit=0, data=0.
- Fill 3 entries, assert flush with drain_ready=1 → next cycle count=0, empty=1. push_ready=0 during the flush cycle.
- Assert reset mid-stream with count=2 → outputs return to reset values asynchronously. The first push after release drains first.
